// File: rtl/fpu_mult_ctrl_pkg.sv
// Shared definitions for the FP multiplier request controller:
// FSM state encoding, watchdog limit, timeout result word, requester count
// and the significand-extraction helper used for the product.
package fpu_mult_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      NORM  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int NREQ         = 2;
   localparam int NORM_TIMEOUT = 48;

   // Watchdog counter width and the count value seen on the last allowed
   // busy cycle (the counter starts at zero on the first NORM cycle).
   localparam int          WD_W    = 6;
   localparam logic [5:0]  WD_LAST = 6'(NORM_TIMEOUT - 1);

   // Quiet NaN 0x7FC00000 with guard/round/sticky cleared.
   localparam logic [34:0] QNAN_OUT = 35'h3FE000000;

   // 24-bit significand: hidden bit set only for normal numbers
   // (a zero exponent field means zero or subnormal).
   function automatic logic [23:0] sig_with_hidden(input logic [31:0] op);
      return {|op[30:23], op[22:0]};
   endfunction

endpackage

// File: rtl/fpu_mult_arb2.sv
// Two-way request arbiter with a priority pointer.
// Build option: FPU_MULT_CTRL_RR_EN selects round-robin; otherwise
// requester 0 always has highest priority and the pointer stays at 0.
module fpu_mult_arb2
   import fpu_mult_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   input  logic            accept,
   output logic [NREQ-1:0] grant
);

   logic ptr_r;

   // Onehot grant: the requester named by the pointer wins a tie.
   always_comb begin
      grant = 2'b00;
      if (ptr_r == 1'b0) begin
         grant[0] = req_valid[0];
         grant[1] = req_valid[1] & ~req_valid[0];
      end else begin
         grant[1] = req_valid[1];
         grant[0] = req_valid[0] & ~req_valid[1];
      end
   end

   // Priority pointer: after an accept it points away from the winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_r <= 1'b0;
      end else if (accept) begin
`ifdef FPU_MULT_CTRL_RR_EN
         ptr_r <= ~grant[1];
`else
         ptr_r <= 1'b0;
`endif
      end
   end

endmodule

// File: rtl/fpu_mult_ctrl.sv
// Request/response controller wrapped around a single-precision multiplier
// datapath. Two requesters share the datapath; one operation is in flight
// at a time: accept -> issue strobe -> wait for normalisation -> response.
// A watchdog substitutes a quiet NaN (with resp_err) if the datapath stays
// busy too long.
// Build option: FPU_MULT_CTRL_RR_EN (round-robin arbitration in fpu_mult_arb2).
module fpu_mult_ctrl
   import fpu_mult_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid,
   input  logic [63:0] req_opa,
   input  logic [63:0] req_opb,
   output logic [1:0]  req_ready,
   output logic [31:0] fm_opa,
   output logic [31:0] fm_opb,
   output logic [47:0] fm_mult_result,
   output logic        fm_new_input,
   input  logic        fm_busy,
   input  logic [34:0] fm_out,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [34:0] resp_data,
   output logic        resp_err
);

   state_t           state_r;
   state_t           state_s;
   logic [1:0]       grant_s;
   logic             accept_s;
   logic             acc_id_s;
   logic [31:0]      acc_opa_s;
   logic [31:0]      acc_opb_s;
   logic             capture_s;
   logic             timeout_s;
   logic [31:0]      hold_opa_r;
   logic [31:0]      hold_opb_r;
   logic             hold_id_r;
   logic [WD_W-1:0]  wd_cnt_r;
   logic [34:0]      resp_data_r;
   logic             resp_err_r;
   logic             resp_id_r;
   logic             resp_valid_r;

   fpu_mult_arb2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .accept    (accept_s),
      .grant     (grant_s)
   );

   // Grants are offered only in IDLE and never while reset is held, so a
   // request dropped before being granted leaves no trace.
   always_comb begin
      if ((state_r == IDLE) && !rst) begin
         req_ready = grant_s;
      end else begin
         req_ready = 2'b00;
      end
   end

   assign accept_s = |(req_valid & req_ready);
   assign acc_id_s = req_ready[1];

   // Operand select for the accepted requester.
   always_comb begin
      if (acc_id_s) begin
         acc_opa_s = req_opa[63:32];
         acc_opb_s = req_opb[63:32];
      end else begin
         acc_opa_s = req_opa[31:0];
         acc_opb_s = req_opb[31:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state and capture/timeout decode.
   always_comb begin
      state_s   = state_r;
      capture_s = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_s = ISSUE;
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            state_s = NORM;
         end
         NORM: begin
            if (!fm_busy) begin
               capture_s = 1'b1;
               state_s   = RESP;
            end else if (wd_cnt_r == WD_LAST) begin
               timeout_s = 1'b1;
               state_s   = RESP;
            end else begin
               state_s   = NORM;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Holding registers, watchdog and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_opa_r   <= 32'd0;
         hold_opb_r   <= 32'd0;
         hold_id_r    <= 1'b0;
         wd_cnt_r     <= 6'd0;
         resp_data_r  <= 35'd0;
         resp_err_r   <= 1'b0;
         resp_id_r    <= 1'b0;
         resp_valid_r <= 1'b0;
      end else begin
         if (accept_s) begin
            hold_opa_r <= acc_opa_s;
            hold_opb_r <= acc_opb_s;
            hold_id_r  <= acc_id_s;
         end
         // Counts NORM cycles; the FSM leaves NORM as soon as busy drops,
         // so every counted cycle is a consecutive busy cycle.
         if (state_r == NORM) begin
            wd_cnt_r <= wd_cnt_r + 6'd1;
         end else begin
            wd_cnt_r <= 6'd0;
         end
         if (capture_s) begin
            resp_data_r <= fm_out;
            resp_err_r  <= 1'b0;
            resp_id_r   <= hold_id_r;
         end else if (timeout_s) begin
            resp_data_r <= QNAN_OUT;
            resp_err_r  <= 1'b1;
            resp_id_r   <= hold_id_r;
         end
         resp_valid_r <= (state_s == RESP);
      end
   end

   assign fm_opa         = hold_opa_r;
   assign fm_opb         = hold_opb_r;
   assign fm_new_input   = (state_r == ISSUE);
   assign fm_mult_result = {24'd0, sig_with_hidden(hold_opa_r)} *
                           {24'd0, sig_with_hidden(hold_opb_r)};
   assign resp_valid     = resp_valid_r;
   assign resp_data      = resp_data_r;
   assign resp_id        = resp_id_r;
   assign resp_err       = resp_err_r;

endmodule

// File: tb/tb_fpu_mult_ctrl.sv
// Directed self-checking bench for fpu_mult_ctrl. The bench plays the
// multiplier datapath (drives fm_busy/fm_out) and checks the controller.
// Latency is counted in clock edges after the accepting edge: resp_valid is
// seen after edge 2+busy_cycles (the accepting cycle being cycle T, that is
// cycle T+3+busy_cycles); a watchdog timeout shows after edge 49.
module tb_fpu_mult_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [63:0] req_opa;
   logic [63:0] req_opb;
   logic [1:0]  req_ready;
   logic [31:0] fm_opa;
   logic [31:0] fm_opb;
   logic [47:0] fm_mult_result;
   logic        fm_new_input;
   logic        fm_busy;
   logic [34:0] fm_out;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [34:0] resp_data;
   logic        resp_err;

   int n_chk  = 0;
   int n_pass = 0;

`ifdef FPU_MULT_CTRL_RR_EN
   localparam logic SECOND_ID = 1'b1;
`else
   localparam logic SECOND_ID = 1'b0;
`endif

   fpu_mult_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_opa        (req_opa),
      .req_opb        (req_opb),
      .req_ready      (req_ready),
      .fm_opa         (fm_opa),
      .fm_opb         (fm_opb),
      .fm_mult_result (fm_mult_result),
      .fm_new_input   (fm_new_input),
      .fm_busy        (fm_busy),
      .fm_out         (fm_out),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_id        (resp_id),
      .resp_data      (resp_data),
      .resp_err       (resp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full operation: request, issue, normalise (nbusy busy cycles),
   // response held for 'stall' cycles, then handshake.
   task automatic run_op(input string tag, input logic [1:0] valid, input logic keep,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [47:0] p0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [47:0] p1,
                         input logic exp_id, input int nbusy, input logic [34:0] fmo,
                         input logic [34:0] exp_data, input logic exp_err,
                         input int exp_lat, input int stall);
      logic [31:0] ea;
      logic [31:0] eb;
      int cyc;
      ea = exp_id ? a1 : a0;
      eb = exp_id ? b1 : b0;
      req_valid = valid;
      req_opa   = {a1, a0};
      req_opb   = {b1, b0};
      fm_out    = fmo;
      fm_busy   = 1'b0;
      #1;
      chk({tag, ".grant"}, req_ready, exp_id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      if (!keep) req_valid = 2'b00;
      chk({tag, ".new_input"}, fm_new_input, 1'b1);
      chk({tag, ".opa"}, fm_opa, ea);
      chk({tag, ".opb"}, fm_opb, eb);
      chk({tag, ".ready_busy"}, req_ready, 2'b00);
      cyc = 0;
      while (!resp_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         fm_busy = (cyc <= nbusy);
         if (cyc == 1) begin
            chk({tag, ".strobe_1cyc"}, fm_new_input, 1'b0);
            chk({tag, ".product"}, fm_mult_result, exp_id ? p1 : p0);
         end
      end
      fm_busy = 1'b0;
      chk({tag, ".latency"}, cyc, exp_lat);
      chk({tag, ".valid"}, resp_valid, 1'b1);
      chk({tag, ".data"}, resp_data, exp_data);
      chk({tag, ".id"}, resp_id, exp_id);
      chk({tag, ".err"}, resp_err, exp_err);
      chk({tag, ".opa_stable"}, fm_opa, ea);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk); #1;
         chk({tag, ".stall_valid"}, resp_valid, 1'b1);
         chk({tag, ".stall_data"}, resp_data, exp_data);
         chk({tag, ".stall_id"}, resp_id, exp_id);
         chk({tag, ".stall_ready"}, req_ready, 2'b00);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, ".done"}, resp_valid, 1'b0);
      if (keep) chk({tag, ".idle_grant"}, |req_ready, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 2'b11;
      req_opa    = 64'h40000000_3FC00000;
      req_opb    = 64'h40400000_3FC00000;
      fm_busy    = 1'b0;
      fm_out     = 35'h7FFFFFFFF;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.req_ready", req_ready, 2'b00);
      chk("rst.new_input", fm_new_input, 1'b0);
      chk("rst.resp_valid", resp_valid, 1'b0);
      chk("rst.resp_data", resp_data, 35'd0);
      chk("rst.resp_id", resp_id, 1'b0);
      chk("rst.resp_err", resp_err, 1'b0);
      chk("rst.fm_opa", fm_opa, 32'd0);
      rst       = 1'b0;
      req_valid = 2'b00;

      // 1.5 * 1.5 = 2.25 from requester 0, datapath never busy.
      run_op("r0_basic", 2'b01, 1'b0,
             32'h3FC00000, 32'h3FC00000, 48'h900000000000,
             32'h00000000, 32'h00000000, 48'h000000000000,
             1'b0, 0, 35'h200800000, 35'h200800000, 1'b0, 2, 0);

      // 2.0 * 3.0 = 6.0 from requester 1, one busy cycle.
      run_op("r1_busy1", 2'b10, 1'b0,
             32'h00000000, 32'h00000000, 48'h000000000000,
             32'h40000000, 32'h40400000, 48'h600000000000,
             1'b1, 1, 35'h206000000, 35'h206000000, 1'b0, 3, 0);

      // Both requesting, held high for two operations.
      run_op("both_1st", 2'b11, 1'b1,
             32'h3FC00000, 32'h3FC00000, 48'h900000000000,
             32'h40000000, 32'h40400000, 48'h600000000000,
             1'b0, 0, 35'h200800000, 35'h200800000, 1'b0, 2, 0);
      run_op("both_2nd", 2'b11, 1'b1,
             32'h3FC00000, 32'h3FC00000, 48'h900000000000,
             32'h40000000, 32'h40400000, 48'h600000000000,
             SECOND_ID,
             0, SECOND_ID ? 35'h206000000 : 35'h200800000,
             SECOND_ID ? 35'h206000000 : 35'h200800000, 1'b0, 2, 0);

      // Subnormal operand (no hidden bit), two busy cycles, response
      // back-pressured for 5 cycles with the request held.
      run_op("stall_sub", 2'b01, 1'b1,
             32'h00400000, 32'h3F800000, 48'h200000000000,
             32'h00000000, 32'h00000000, 48'h000000000000,
             1'b0, 2, 35'h012345678, 35'h012345678, 1'b0, 4, 5);
      req_valid = 2'b00;

      // Datapath stuck busy: watchdog returns qNaN with resp_err.
      run_op("timeout", 2'b10, 1'b0,
             32'h00000000, 32'h00000000, 48'h000000000000,
             32'h40000000, 32'h40400000, 48'h600000000000,
             1'b1, 1000, 35'h206000000, 35'h3FE000000, 1'b1, 49, 1);

      // Leave stale response registers from a previous timeout response,
      // then abort a new operation mid-NORM with reset.
      req_valid = 2'b10;
      req_opa   = 64'h40000000_3FC00000;
      req_opb   = 64'h40400000_3FC00000;
      fm_busy   = 1'b1;
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (4) @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = 2'b11;
      @(posedge clk); #1;
      chk("abort.req_ready", req_ready, 2'b00);
      chk("abort.new_input", fm_new_input, 1'b0);
      chk("abort.resp_valid", resp_valid, 1'b0);
      chk("abort.resp_err", resp_err, 1'b0);
      chk("abort.resp_id", resp_id, 1'b0);
      chk("abort.resp_data", resp_data, 35'd0);
      chk("abort.fm_opa", fm_opa, 32'd0);
      chk("abort.fm_opb", fm_opb, 32'd0);
      rst       = 1'b0;
      req_valid = 2'b00;
      fm_busy   = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         chk("abort.no_resp", resp_valid, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
